// File: rtl/multicycle_alu_pkg.sv
// Shared ALU operation codes and state encoding for the multicycle ALU.
package multicycle_alu_pkg;

    localparam logic [3:0] ALU_CTL_AND  = 4'd0;
    localparam logic [3:0] ALU_CTL_OR   = 4'd1;
    localparam logic [3:0] ALU_CTL_XOR  = 4'd2;
    localparam logic [3:0] ALU_CTL_NAND = 4'd3;
    localparam logic [3:0] ALU_CTL_NOR  = 4'd4;
    localparam logic [3:0] ALU_CTL_ADD  = 4'd5;
    localparam logic [3:0] ALU_CTL_SUB  = 4'd6;
    localparam logic [3:0] ALU_CTL_SLL  = 4'd7;
    localparam logic [3:0] ALU_CTL_SRL  = 4'd8;
    localparam logic [3:0] ALU_CTL_SRA  = 4'd9;
    localparam logic [3:0] ALU_CTL_MUL  = 4'd10;
    localparam logic [3:0] ALU_CTL_DIV  = 4'd11;

    typedef enum logic [1:0] {
        MALU_ST_IDLE = 2'd0,
        MALU_ST_BUSY = 2'd1,
        MALU_ST_DONE = 2'd2
    } malu_state_e;

endpackage

// File: rtl/multicycle_alu_muldiv_iter.sv
// Iterative WIDTH-step engine: unsigned shift-add multiply and restoring divide.
module muldiv_iter #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             op_div_i,
    input  logic [WIDTH-1:0] op1_i,
    input  logic [WIDTH-1:0] op2_i,
    output logic             done_c,
    output logic [WIDTH-1:0] hi_c,
    output logic [WIDTH-1:0] lo_c
);

    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    logic             busy_q;
    logic             div_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] b_q;

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             q_bit;

    // One step of either algorithm; hi_c/lo_c are the accumulator after this step.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        shifted = {hi_q, lo_q[WIDTH-1]};
        diff    = shifted - {1'b0, b_q};
        q_bit   = ~diff[WIDTH];
        if (div_q) begin
            hi_c = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
            lo_c = {lo_q[WIDTH-2:0], q_bit};
        end else begin
            hi_c = sum[WIDTH:1];
            lo_c = {sum[0], lo_q[WIDTH-1:1]};
        end
        done_c = busy_q && (cnt_q == CNT_W'(WIDTH - 1));
    end

    // Load operands on start, then advance one step per busy cycle.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            busy_q <= 1'b0;
            div_q  <= 1'b0;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            b_q    <= '0;
        end else if (start_i) begin
            busy_q <= 1'b1;
            div_q  <= op_div_i;
            cnt_q  <= '0;
            hi_q   <= '0;
            lo_q   <= op_div_i ? op1_i : op2_i;
            b_q    <= op_div_i ? op2_i : op1_i;
        end else if (busy_q) begin
            hi_q <= hi_c;
            lo_q <= lo_c;
            if (done_c) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/multicycle_alu.sv
// Clocked ALU with valid/ready handshake; single-cycle logic/arith/shift, iterative MUL/DIV.
module multicycle_alu
    import multicycle_alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CTL_W = 4
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             Valid_i,
    output logic             Ready_o,
    input  logic [CTL_W-1:0] ALUCtl_i,
    input  logic [WIDTH-1:0] Op1_i,
    input  logic [WIDTH-1:0] Op2_i,
    output logic             Valid_o,
    input  logic             Ready_i,
    output logic [WIDTH-1:0] Res_o,
    output logic [WIDTH-1:0] ResHi_o,
    output logic             Zero_o,
    output logic             Err_o
);

    localparam int unsigned SHW = $clog2(WIDTH);

    malu_state_e      state_q;
    logic [SHW-1:0]   sh;
    logic [WIDTH-1:0] sc_res;
    logic             sc_legal;
    logic             is_mul;
    logic             is_div;
    logic             start;
    logic             eng_done_c;
    logic [WIDTH-1:0] eng_hi_c;
    logic [WIDTH-1:0] eng_lo_c;

    assign Ready_o = (state_q == MALU_ST_IDLE);
    assign start   = Ready_o && Valid_i && (is_mul || (is_div && (Op2_i != '0)));

    // Single-cycle datapath and operation decode.
    always_comb begin
        sh       = Op2_i[SHW-1:0];
        sc_res   = '0;
        sc_legal = 1'b1;
        is_mul   = 1'b0;
        is_div   = 1'b0;
        case (ALUCtl_i)
            CTL_W'(ALU_CTL_AND):  sc_res = Op1_i & Op2_i;
            CTL_W'(ALU_CTL_OR):   sc_res = Op1_i | Op2_i;
            CTL_W'(ALU_CTL_XOR):  sc_res = Op1_i ^ Op2_i;
            CTL_W'(ALU_CTL_NAND): sc_res = ~(Op1_i & Op2_i);
            CTL_W'(ALU_CTL_NOR):  sc_res = ~(Op1_i | Op2_i);
            CTL_W'(ALU_CTL_ADD):  sc_res = Op1_i + Op2_i;
            CTL_W'(ALU_CTL_SUB):  sc_res = Op1_i - Op2_i;
            CTL_W'(ALU_CTL_SLL):  sc_res = Op1_i << sh;
            CTL_W'(ALU_CTL_SRL):  sc_res = Op1_i >> sh;
            CTL_W'(ALU_CTL_SRA):  sc_res = WIDTH'($signed(Op1_i) >>> sh);
            CTL_W'(ALU_CTL_MUL):  is_mul = 1'b1;
            CTL_W'(ALU_CTL_DIV):  is_div = 1'b1;
            default:              sc_legal = 1'b0;
        endcase
    end

    muldiv_iter #(
        .WIDTH(WIDTH)
    ) u_muldiv_iter (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .start_i  (start),
        .op_div_i (is_div),
        .op1_i    (Op1_i),
        .op2_i    (Op2_i),
        .done_c   (eng_done_c),
        .hi_c     (eng_hi_c),
        .lo_c     (eng_lo_c)
    );

    // Control FSM and result registers; results hold in DONE until consumed.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= MALU_ST_IDLE;
            Valid_o <= 1'b0;
            Res_o   <= '0;
            ResHi_o <= '0;
            Zero_o  <= 1'b1;
            Err_o   <= 1'b0;
        end else begin
            case (state_q)
                MALU_ST_IDLE: begin
                    if (Valid_i) begin
                        if (start) begin
                            state_q <= MALU_ST_BUSY;
                        end else if (is_div) begin
                            state_q <= MALU_ST_DONE;
                            Valid_o <= 1'b1;
                            Res_o   <= '1;
                            ResHi_o <= Op1_i;
                            Zero_o  <= 1'b0;
                            Err_o   <= 1'b1;
                        end else begin
                            state_q <= MALU_ST_DONE;
                            Valid_o <= 1'b1;
                            Res_o   <= sc_res;
                            ResHi_o <= '0;
                            Zero_o  <= (sc_res == '0);
                            Err_o   <= ~sc_legal;
                        end
                    end
                end
                MALU_ST_BUSY: begin
                    if (eng_done_c) begin
                        state_q <= MALU_ST_DONE;
                        Valid_o <= 1'b1;
                        Res_o   <= eng_lo_c;
                        ResHi_o <= eng_hi_c;
                        Zero_o  <= (eng_lo_c == '0);
                        Err_o   <= 1'b0;
                    end
                end
                MALU_ST_DONE: begin
                    if (Ready_i) begin
                        state_q <= MALU_ST_IDLE;
                        Valid_o <= 1'b0;
                    end
                end
                default: state_q <= MALU_ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Directed self-checking bench for multicycle_alu at WIDTH=32 and WIDTH=8.
module tb_multicycle_alu;
    import multicycle_alu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        v_i32 = 1'b0, r_o32, v_o32, r_i32 = 1'b1, z32, e32;
    logic [3:0]  ctl32 = 4'd0;
    logic [31:0] a32 = '0, b32 = '0, res32, hi32;

    logic        v_i8 = 1'b0, r_o8, v_o8, r_i8 = 1'b1, z8, e8;
    logic [3:0]  ctl8 = 4'd0;
    logic [7:0]  a8 = '0, b8 = '0, res8, hi8;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multicycle_alu #(.WIDTH(32), .CTL_W(4)) dut32 (
        .clk_i(clk), .rst_n_i(rst_n), .Valid_i(v_i32), .Ready_o(r_o32),
        .ALUCtl_i(ctl32), .Op1_i(a32), .Op2_i(b32), .Valid_o(v_o32),
        .Ready_i(r_i32), .Res_o(res32), .ResHi_o(hi32), .Zero_o(z32), .Err_o(e32)
    );

    multicycle_alu #(.WIDTH(8), .CTL_W(4)) dut8 (
        .clk_i(clk), .rst_n_i(rst_n), .Valid_i(v_i8), .Ready_o(r_o8),
        .ALUCtl_i(ctl8), .Op1_i(a8), .Op2_i(b8), .Valid_o(v_o8),
        .Ready_i(r_i8), .Res_o(res8), .ResHi_o(hi8), .Zero_o(z8), .Err_o(e8)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request on the 32-bit DUT and return the cycle Valid_o was first seen.
    task automatic run32(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                         output int lat);
        int w = 0;
        while (!r_o32 && w < 50) begin tick(); w++; end
        ctl32 = c; a32 = a; b32 = b; v_i32 = 1'b1;
        tick();
        v_i32 = 1'b0; a32 = '0; b32 = '0; ctl32 = 4'd0;
        lat = 1;
        while (!v_o32 && lat < 200) begin tick(); lat++; end
    endtask

    task automatic run8(input logic [3:0] c, input logic [7:0] a, input logic [7:0] b,
                        output int lat);
        int w = 0;
        while (!r_o8 && w < 50) begin tick(); w++; end
        ctl8 = c; a8 = a; b8 = b; v_i8 = 1'b1;
        tick();
        v_i8 = 1'b0; a8 = '0; b8 = '0; ctl8 = 4'd0;
        lat = 1;
        while (!v_o8 && lat < 200) begin tick(); lat++; end
    endtask

    task automatic test_reset();
        checks++; if (v_o32 !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", v_o32); end
        checks++; if (r_o32 !== 1'b1) begin errors++; $display("FAIL rst_ready got %b want 1", r_o32); end
        checks++; if (res32 !== 32'h0 || hi32 !== 32'h0) begin errors++; $display("FAIL rst_res got %h/%h want 0/0", hi32, res32); end
        checks++; if (e32 !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", e32); end
    endtask

    task automatic test_single_cycle();
        int lat;
        run32(ALU_CTL_ADD, 32'hFFFF_FFFF, 32'h1, lat);
        checks++; if (lat != 1) begin errors++; $display("FAIL add_wrap_lat got %0d want 1", lat); end
        checks++; if (res32 !== 32'h0 || z32 !== 1'b1) begin errors++; $display("FAIL add_wrap got %h z=%b want 0 z=1", res32, z32); end
        checks++; if (hi32 !== 32'h0 || e32 !== 1'b0) begin errors++; $display("FAIL add_wrap_hi got %h e=%b want 0 e=0", hi32, e32); end
        tick();
        run32(ALU_CTL_SRA, 32'h8000_0000, 32'h4, lat);
        checks++; if (res32 !== 32'hF800_0000 || lat != 1) begin errors++; $display("FAIL sra got %h lat %0d want f8000000 lat 1", res32, lat); end
        tick();
        run32(ALU_CTL_SLL, 32'h1, 32'h21, lat);
        checks++; if (res32 !== 32'h2) begin errors++; $display("FAIL sll_mask got %h want 00000002", res32); end
        tick();
        run32(ALU_CTL_SRL, 32'h8000_0000, 32'h4, lat);
        checks++; if (res32 !== 32'h0800_0000) begin errors++; $display("FAIL srl got %h want 08000000", res32); end
        tick();
        run32(ALU_CTL_NOR, 32'h0F0F_0000, 32'h00F0_00FF, lat);
        checks++; if (res32 !== 32'hF000_FF00 || z32 !== 1'b0) begin errors++; $display("FAIL nor got %h z=%b want f000ff00 z=0", res32, z32); end
        tick();
    endtask

    task automatic test_mul();
        int lat;
        run32(ALU_CTL_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        checks++; if (lat != 33) begin errors++; $display("FAIL mul_lat got %0d want 33", lat); end
        checks++; if (hi32 !== 32'hFFFF_FFFE || res32 !== 32'h1) begin errors++; $display("FAIL mul got %h_%h want fffffffe_00000001", hi32, res32); end
        tick();
        run32(ALU_CTL_MUL, 32'h1234_5678, 32'h10, lat);
        checks++; if (hi32 !== 32'h1 || res32 !== 32'h2345_6780) begin errors++; $display("FAIL mul2 got %h_%h want 00000001_23456780", hi32, res32); end
        tick();
    endtask

    task automatic test_div();
        int lat;
        run32(ALU_CTL_DIV, 32'd100, 32'd7, lat);
        checks++; if (res32 !== 32'd14 || hi32 !== 32'd2 || e32 !== 1'b0) begin errors++; $display("FAIL div got q=%0d r=%0d e=%b want 14 2 0", res32, hi32, e32); end
        checks++; if (lat != 33) begin errors++; $display("FAIL div_lat got %0d want 33", lat); end
        tick();
        run32(ALU_CTL_DIV, 32'd5, 32'd0, lat);
        checks++; if (res32 !== 32'hFFFF_FFFF || hi32 !== 32'd5 || e32 !== 1'b1) begin errors++; $display("FAIL div0 got %h r=%h e=%b want ffffffff 5 1", res32, hi32, e32); end
        checks++; if (lat != 1) begin errors++; $display("FAIL div0_lat got %0d want 1", lat); end
        tick();
    endtask

    task automatic test_back_pressure();
        int lat;
        r_i32 = 1'b0;
        run32(ALU_CTL_SUB, 32'd10, 32'd3, lat);
        checks++; if (res32 !== 32'd7 || lat != 1) begin errors++; $display("FAIL sub got %0d lat %0d want 7 lat 1", res32, lat); end
        for (int i = 0; i < 20; i++) begin
            v_i32 = i[0]; ctl32 = ALU_CTL_ADD; a32 = 32'd1; b32 = 32'd1;
            tick();
            checks++;
            if (res32 !== 32'd7 || v_o32 !== 1'b1 || r_o32 !== 1'b0 || z32 !== 1'b0 || e32 !== 1'b0) begin
                errors++;
                $display("FAIL bp_hold cyc %0d got res=%0d v=%b rdy=%b z=%b e=%b want 7 1 0 0 0", i, res32, v_o32, r_o32, z32, e32);
            end
        end
        v_i32 = 1'b0; a32 = '0; b32 = '0; ctl32 = 4'd0;
        r_i32 = 1'b1;
        tick();
        checks++; if (r_o32 !== 1'b1 || v_o32 !== 1'b0) begin errors++; $display("FAIL bp_release got rdy=%b v=%b want 1 0", r_o32, v_o32); end
        tick();
        checks++; if (v_o32 !== 1'b0) begin errors++; $display("FAIL bp_no_queue got v=%b want 0", v_o32); end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        logic stale;
        ctl32 = ALU_CTL_MUL; a32 = 32'd9; b32 = 32'd9; v_i32 = 1'b1;
        tick();
        v_i32 = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        rst_n = 1'b0;
        #1;
        checks++; if (v_o32 !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", v_o32); end
        #3 rst_n = 1'b1;
        tick();
        checks++; if (r_o32 !== 1'b1) begin errors++; $display("FAIL midrst_ready got %b want 1", r_o32); end
        stale = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (v_o32 !== 1'b0) stale = 1'b1;
            tick();
        end
        checks++; if (stale !== 1'b0) begin errors++; $display("FAIL midrst_stale got %b want 0", stale); end
        run32(ALU_CTL_ADD, 32'd3, 32'd4, lat);
        checks++; if (res32 !== 32'd7 || lat != 1) begin errors++; $display("FAIL midrst_add got %0d lat %0d want 7 lat 1", res32, lat); end
        tick();
    endtask

    task automatic test_illegal();
        int lat;
        run32(4'hF, 32'h1234, 32'h5678, lat);
        checks++; if (e32 !== 1'b1 || res32 !== 32'h0 || hi32 !== 32'h0 || z32 !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL ill32 got e=%b res=%h hi=%h z=%b lat %0d want 1 0 0 1 lat 1", e32, res32, hi32, z32, lat);
        end
        tick();
        run8(4'hC, 8'h12, 8'h34, lat);
        checks++; if (e8 !== 1'b1 || res8 !== 8'h0 || z8 !== 1'b1 || lat != 1) begin
            errors++; $display("FAIL ill8 got e=%b res=%h z=%b lat %0d want 1 0 1 lat 1", e8, res8, z8, lat);
        end
        tick();
    endtask

    task automatic test_width8();
        int lat;
        run8(ALU_CTL_MUL, 8'hFF, 8'hFF, lat);
        checks++; if (hi8 !== 8'hFE || res8 !== 8'h01) begin errors++; $display("FAIL mul8 got %h_%h want fe_01", hi8, res8); end
        checks++; if (lat != 9) begin errors++; $display("FAIL mul8_lat got %0d want 9", lat); end
        tick();
        run8(ALU_CTL_DIV, 8'd200, 8'd7, lat);
        checks++; if (res8 !== 8'd28 || hi8 !== 8'd4 || e8 !== 1'b0 || lat != 9) begin
            errors++; $display("FAIL div8 got q=%0d r=%0d e=%b lat %0d want 28 4 0 lat 9", res8, hi8, e8, lat);
        end
        tick();
        run8(ALU_CTL_SRA, 8'h90, 8'h0A, lat);
        checks++; if (res8 !== 8'hE4) begin errors++; $display("FAIL sra8 got %h want e4", res8); end
        tick();
    endtask

    initial begin
        #23 rst_n = 1'b1;
        tick();
        test_reset();
        test_single_cycle();
        test_mul();
        test_div();
        test_back_pressure();
        test_reset_mid_mul();
        test_illegal();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
